// File: rtl/game_status_sm.sv
// End-of-game status FSM: tracks lives/score, post-hit invulnerability and sticky gameOver/win.
// Optional play-time limit is enabled by defining GAME_TIME_LIMIT_EN.
module game_status_sm #(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned WIN_SCORE    = 50,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned COOLDOWN_CYC = 50000000,
  parameter int unsigned TIME_LIMIT_S = 99
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startGame,
  input  logic               player_hit,
  input  logic               enemy_killed,
  input  logic               oneSec,
  output logic               gameOver,
  output logic               win,
  output logic               playing,
  output logic               invulnerable,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [6:0]         time_left
);

  localparam int unsigned CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_INVULN    = 3'd2,
    S_GAME_OVER = 3'd3,
    S_WIN       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               game_over_q, win_q, playing_q, invuln_q;
  logic [SCORE_W-1:0] score_inc_s;
  logic               won_s;
  logic               timeout_s;

`ifdef GAME_TIME_LIMIT_EN
  logic [6:0] time_q, time_d;

  // Play timer: reload on start, count down on oneSec while in play
  always_comb begin
    time_d    = time_q;
    timeout_s = 1'b0;
    if (startGame) begin
      time_d = 7'(TIME_LIMIT_S);
    end else if ((state_q == S_PLAY || state_q == S_INVULN) && oneSec && (time_q != 7'd0)) begin
      time_d    = time_q - 7'd1;
      timeout_s = (time_q == 7'd1);
    end else begin
      time_d = time_q;
    end
  end

  // Timer register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      time_q <= 7'd0;
    end else begin
      time_q <= time_d;
    end
  end

  assign time_left = time_q;
`else
  logic unused_one_sec_s;
  assign unused_one_sec_s = oneSec;
  assign timeout_s        = 1'b0;
  assign time_left        = 7'd0;
`endif

  assign score_inc_s = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
  assign won_s       = enemy_killed && (32'(score_inc_s) >= WIN_SCORE);

  // Next-state logic; a win in the same cycle as a hit discards the hit
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    if (startGame) begin
      state_d = S_PLAY;
      lives_d = 3'(INIT_LIVES);
      score_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          score_d = enemy_killed ? score_inc_s : score_q;
          if (won_s) begin
            state_d = S_WIN;
          end else if (player_hit) begin
            lives_d = lives_q - 3'd1;
            cnt_d   = CNT_W'(COOLDOWN_CYC - 1);
            state_d = ((lives_q <= 3'd1) || timeout_s) ? S_GAME_OVER : S_INVULN;
          end else if (timeout_s) begin
            state_d = S_GAME_OVER;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_INVULN: begin
          score_d = enemy_killed ? score_inc_s : score_q;
          cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
          if (won_s) begin
            state_d = S_WIN;
          end else if (timeout_s) begin
            state_d = S_GAME_OVER;
          end else if (cnt_q == '0) begin
            state_d = S_PLAY;
          end else begin
            state_d = S_INVULN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, counters and registered status flags
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      lives_q     <= 3'd0;
      score_q     <= '0;
      cnt_q       <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      playing_q   <= 1'b0;
      invuln_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      game_over_q <= (state_d == S_GAME_OVER);
      win_q       <= (state_d == S_WIN);
      playing_q   <= (state_d == S_PLAY) || (state_d == S_INVULN);
      invuln_q    <= (state_d == S_INVULN);
    end
  end

  assign gameOver     = game_over_q;
  assign win          = win_q;
  assign playing      = playing_q;
  assign invulnerable = invuln_q;
  assign lives        = lives_q;
  assign score        = score_q;

endmodule

// File: doc/game_status_sm.md
Name: game_status_sm

Overview:
- Producer of the end-of-game status consumed by the end-game message FSM.
- Tracks lives and score during play and enforces a post-hit invulnerability window.
- Drives sticky, mutually exclusive gameOver / win levels.
- Sits between the collision/scoring logic and the message/draw layer; also exports lives/score for the HUD.

Parameters:
- INIT_LIVES, 3, lives loaded on game start (1..7).
- WIN_SCORE, 50, score at or above which the game is won.
- SCORE_W, 8, score counter width; score saturates at 2^SCORE_W-1.
- COOLDOWN_CYC, 50000000, clk cycles of invulnerability after an accepted hit (>=1).
- TIME_LIMIT_S, 99, seconds of play allowed (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startGame  in  1  one-cycle pulse; starts or restarts a game.
- player_hit  in  1  one-cycle pulse; player collided with an enemy or shot.
- enemy_killed  in  1  one-cycle pulse; adds 1 to score.
- oneSec  in  1  one-cycle pulse every second.
- gameOver  out  1  sticky level; game lost.
- win  out  1  sticky level; game won.
- playing  out  1  high in s_play and s_invuln.
- invulnerable  out  1  high in s_invuln.
- lives  out  3  remaining lives.
- score  out  SCORE_W  current score.
- time_left  out  7  seconds remaining (0 without the feature).

Behaviour:
- Reset (resetN low, async): state s_idle; gameOver=0, win=0, lives=0, score=0, cooldown counter=0, time_left=0. All outputs are registered.
- States: s_idle, s_play, s_invuln, s_game_over, s_win.
- s_idle:
  - startGame -> s_play next cycle; lives=INIT_LIVES, score=0, time_left=TIME_LIMIT_S.
  - Hit, kill and oneSec pulses are ignored.
- s_play:
  - player_hit: lives decrements, visible 1 cycle later.
  - Hit with lives>1 -> s_invuln, cooldown counter loaded with COOLDOWN_CYC-1.
  - Hit with lives==1 -> lives=0, s_game_over; gameOver=1 in the cycle after the hit.
  - enemy_killed: score+1, saturating.
  - If the new score >= WIN_SCORE -> s_win; win=1 in the cycle after the kill.
- s_invuln:
  - player_hit is ignored.
  - enemy_killed scores as in s_play, including the win transition.
  - Counter decrements each cycle. When it reaches 0 -> s_play, so invulnerable is high for exactly COOLDOWN_CYC cycles.
- Simultaneous hit and kill in the same cycle:
  - The kill is always applied.
  - If the kill reaches WIN_SCORE, win takes precedence: -> s_win and the hit is discarded (lives unchanged).
  - Otherwise the hit is processed normally.
  - gameOver and win are never high together.
- s_game_over / s_win:
  - Terminal. lives and score are frozen; all pulses are ignored except startGame.
  - startGame clears gameOver/win in the next cycle and re-enters s_play with fresh lives, score and time_left.
- startGame in s_play or s_invuln: restarts the game (same reload as from s_idle); the cooldown counter is cleared.
- Async reset mid-game returns immediately to the reset values above.

Optional Feature:
- Macro: GAME_TIME_LIMIT_EN.
- Defined:
  - time_left is loaded with TIME_LIMIT_S on start.
  - Each oneSec pulse in s_play or s_invuln decrements time_left.
  - The decrement that reaches 0 forces s_game_over (gameOver=1 next cycle) unless the same cycle produces a win; win has priority.
  - time_left is frozen in terminal states.
- Undefined: no timer logic; time_left is tied to 0; oneSec is unused.

Test Plan:
Bench parameters for all scenarios: INIT_LIVES=3, WIN_SCORE=5, COOLDOWN_CYC=4, TIME_LIMIT_S=3.
- Reset, then startGame pulse -> next cycle playing=1, lives=3, score=0, gameOver=0, win=0.
- player_hit at cycle T -> lives=2 at T+1; invulnerable=1 for cycles T+1..T+4. A second hit at T+2 leaves lives=2. A hit at T+6 gives lives=1.
- Three hits each spaced more than 4 cycles apart -> lives 3->2->1->0. gameOver=1 the cycle after the third hit; it stays 1 through a further 10 hits and kills.
- 5 enemy_killed pulses -> score 1..5, win=1 after the 5th. player_hit driven in the same cycle as the 5th kill with lives=1 -> win=1, gameOver=0, lives=1.
- In s_win, startGame -> next cycle win=0, score=0, lives=3, playing=1. Asserting resetN low mid-invulnerability -> all outputs immediately 0, state s_idle.
- GAME_TIME_LIMIT_EN defined: start, then 3 oneSec pulses -> time_left 3->2->1->0 and gameOver=1 the cycle after the 3rd pulse. Macro undefined: time_left stays 0 and no gameOver results.
